// File: rtl/crc16_check_pkg.sv
// Shared CRC-16 (Gen2/CCITT) constants and checker state type.
// Also used by the generator side for POLY/PRESET.
package crc16_check_pkg;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;
    localparam int unsigned CRC16_MIN_BITS = 16;
    localparam int unsigned CRC16_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } crc16_state_t;
endpackage

// File: rtl/crc16_check_if.sv
// Demodulator/parser-facing bit stream and result bundle of the CRC-16 checker.
interface crc16_check_if #(
    parameter int unsigned CNT_W = 8
);
    logic             sof;
    logic             bit_valid;
    logic             bit_in;
    logic             eof;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic             short_err;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output sof, bit_valid, bit_in, eof,
        input  busy, done, crc_ok, short_err, bit_count
    );

    modport slave (
        input  sof, bit_valid, bit_in, eof,
        output busy, done, crc_ok, short_err, bit_count
    );
endinterface

// File: rtl/crc16_check_step.sv
// One-bit MSB-first CRC-16 update; shared with the tag's CRC-16 generator.
module crc16_step #(
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic [15:0] crc_in,
    input  logic        bit_in,
    output logic [15:0] crc_out
);
    logic fb;

    always_comb begin
        fb      = bit_in ^ crc_in[15];
        crc_out = {crc_in[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
endmodule

// File: rtl/crc16_check.sv
// Receive-side CRC-16 checker: absorbs command bits plus trailing CRC and
// reports crc_ok / short_err against the Gen2 residue at end of frame.
module crc16_check
    import crc16_check_pkg::*;
#(
    parameter logic [15:0] POLY     = CRC16_POLY,
    parameter logic [15:0] PRESET   = CRC16_PRESET,
    parameter logic [15:0] RESIDUE  = CRC16_RESIDUE,
    parameter int unsigned MIN_BITS = CRC16_MIN_BITS,
    parameter int unsigned CNT_W    = CRC16_CNT_W
) (
    input  logic          clk,
    input  logic          reset_n,
    crc16_check_if.slave  bus
);
    crc16_state_t     state_q, state_d;
    logic [15:0]      crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             crc_ok_q, crc_ok_d;
    logic             short_err_q, short_err_d;

    logic [15:0]      step_base;
    logic [15:0]      step_out;
    logic [CNT_W-1:0] cnt_inc;

    // A sof restarts from PRESET, so a same-cycle bit steps from PRESET.
    assign step_base = bus.sof ? PRESET : crc_q;

    crc16_step #(.POLY(POLY)) u_step (
        .crc_in  (step_base),
        .bit_in  (bus.bit_in),
        .crc_out (step_out)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        crc_ok_d    = crc_ok_q;
        short_err_d = short_err_q;

        if (bus.sof) begin
            state_d     = ST_RUN;
            crc_d       = bus.bit_valid ? step_out : PRESET;
            cnt_d       = bus.bit_valid ? CNT_W'(1) : '0;
            crc_ok_d    = 1'b0;
            short_err_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.eof) begin
                        state_d     = ST_DONE;
                        crc_ok_d    = 1'b0;
                        short_err_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.bit_valid) begin
                        crc_d = step_out;
                        cnt_d = cnt_inc;
                    end
                    // Judge on the post-update register/count so an eof-cycle bit counts.
                    if (bus.eof) begin
                        state_d     = ST_DONE;
                        short_err_d = (cnt_d < CNT_W'(MIN_BITS + 16));
                        crc_ok_d    = ~short_err_d & (crc_d == RESIDUE);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= PRESET;
            cnt_q       <= '0;
            crc_ok_q    <= 1'b0;
            short_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            crc_ok_q    <= crc_ok_d;
            short_err_q <= short_err_d;
        end
    end

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.crc_ok    = crc_ok_q;
    assign bus.short_err = short_err_q;
    assign bus.bit_count = cnt_q;
endmodule
